// File: rtl/axi2ahb_rdata_buf.sv
// AXI R-channel return buffer for the AXI-to-AHB bridge: AHB read beats are tagged with ID/RLAST from a command queue.
// Optional build macro AXI2AHB_RDATA_ERR_EN: when defined, beats captured with HRESP high return SLVERR.
module axi2ahb_rdata_buf #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int CMD_DEPTH      = 2
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  output logic [AXI_ID_WIDTH-1:0]   RID,
  output logic [AXI_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  input  logic [AXI_DATA_WIDTH-1:0] HRDATA,
  input  logic                      HREADY,
  input  logic                      HRESP,
  input  logic                      ahb_rd_phase,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic [7:0]                cmd_len,
  output logic                      rdata_space,
  output logic                      ovf_err
);

  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int FCW = FPW + 1;
  localparam int CPW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CCW = $clog2(CMD_DEPTH + 1);

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [7:0]              len;
  } cmd_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic                      err;
    logic                      last;
    logic [AXI_ID_WIDTH-1:0]   id;
  } beat_t;

  function automatic logic [CPW-1:0] cmd_ptr_inc(input logic [CPW-1:0] p);
    return (p == CPW'(CMD_DEPTH - 1)) ? '0 : p + CPW'(1);
  endfunction

  cmd_t  cmd_mem_q  [CMD_DEPTH];
  beat_t fifo_mem_q [FIFO_DEPTH];

  logic [CPW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
  logic [CCW-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [FPW-1:0] fifo_wr_ptr_q, fifo_wr_ptr_d, fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic           ovf_err_q, ovf_err_d;

  logic  capture, cmd_empty, fifo_full, beat_push, beat_drop, beat_pop;
  logic  beat_last, cmd_push, cmd_pop, cap_err;
  cmd_t  head_cmd;
  beat_t new_beat, out_beat;

`ifdef AXI2AHB_RDATA_ERR_EN
  assign cap_err = HRESP;
`else
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign cap_err      = 1'b0;
`endif

  // Full/empty come from registered counts, so a same-cycle pop never makes room for a push.
  assign capture   = ahb_rd_phase && HREADY;
  assign cmd_empty = (cmd_cnt_q == '0);
  assign fifo_full = (fifo_cnt_q == FCW'(FIFO_DEPTH));
  assign beat_push = capture && !fifo_full && !cmd_empty;
  assign beat_drop = capture && (fifo_full || cmd_empty);
  assign beat_pop  = RVALID && RREADY;

  assign head_cmd  = cmd_mem_q[cmd_rd_ptr_q];
  assign beat_last = (beat_cnt_q == head_cmd.len);
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_pop   = beat_push && beat_last;

  assign new_beat = '{data: HRDATA, err: cap_err, last: beat_last, id: head_cmd.id};

  // NOTE: every always_comb output gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cmd_wr_ptr_d  = cmd_wr_ptr_q;
    cmd_rd_ptr_d  = cmd_rd_ptr_q;
    cmd_cnt_d     = cmd_cnt_q;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    ovf_err_d     = ovf_err_q | beat_drop;

    if (cmd_push) cmd_wr_ptr_d = cmd_ptr_inc(cmd_wr_ptr_q);
    if (cmd_pop)  cmd_rd_ptr_d = cmd_ptr_inc(cmd_rd_ptr_q);
    case ({cmd_push, cmd_pop})
      2'b10:   cmd_cnt_d = cmd_cnt_q + CCW'(1);
      2'b01:   cmd_cnt_d = cmd_cnt_q - CCW'(1);
      default: cmd_cnt_d = cmd_cnt_q;
    endcase

    if (beat_push) begin
      fifo_wr_ptr_d = fifo_wr_ptr_q + FPW'(1);
      beat_cnt_d    = beat_last ? 8'd0 : beat_cnt_q + 8'd1;
    end
    if (beat_pop) fifo_rd_ptr_d = fifo_rd_ptr_q + FPW'(1);
    case ({beat_push, beat_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cmd_wr_ptr_q  <= '0;
      cmd_rd_ptr_q  <= '0;
      cmd_cnt_q     <= '0;
      fifo_wr_ptr_q <= '0;
      fifo_rd_ptr_q <= '0;
      fifo_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      ovf_err_q     <= 1'b0;
    end else begin
      cmd_wr_ptr_q  <= cmd_wr_ptr_d;
      cmd_rd_ptr_q  <= cmd_rd_ptr_d;
      cmd_cnt_q     <= cmd_cnt_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  // NOTE: storage arrays are not reset; the counts alone decide which entries are valid.
  always_ff @(posedge ACLK) begin
    if (cmd_push)  cmd_mem_q[cmd_wr_ptr_q]   <= '{id: cmd_id, len: cmd_len};
    if (beat_push) fifo_mem_q[fifo_wr_ptr_q] <= new_beat;
  end

  assign RVALID   = (fifo_cnt_q != '0);
  assign out_beat = RVALID ? fifo_mem_q[fifo_rd_ptr_q] : '0;
  assign RID      = out_beat.id;
  assign RDATA    = out_beat.data;
  assign RLAST    = out_beat.last;
  assign RRESP    = {out_beat.err, 1'b0};

  assign cmd_ready   = (cmd_cnt_q != CCW'(CMD_DEPTH));
  assign rdata_space = (fifo_cnt_q <= FCW'(FIFO_DEPTH - 2));
  assign ovf_err     = ovf_err_q;

endmodule
